wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 142 ++++++++++++++
 tb/tb_wb_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back pipeline stage: captures the MEM-stage instruction, formats loads,
// selects the write-back result and counts retired instructions.
module wb_stage #(
   parameter int  XLEN    = 32,
   parameter int  NUM_SRC = 4,
   parameter int  CNT_W   = 32,
   localparam int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_valid_M,
   input  logic             i_stall_W,
   input  logic             i_flush_W,
   input  logic [4:0]       i_rd_addr_M,
   input  logic             i_rd_wren_M,
   input  logic [SEL_W-1:0] i_wb_sel_M,
   input  logic [XLEN-1:0]  i_alu_data_M,
   input  logic [XLEN-1:0]  i_ld_data_M,
   input  logic [XLEN-1:0]  i_pc_4_M,
   input  logic [XLEN-1:0]  i_csr_data_M,
   input  logic [2:0]       i_ld_funct3_M,
   input  logic [1:0]       i_ld_addr_lo_M,
   output logic [XLEN-1:0]  o_result_W,
   output logic [4:0]       o_rd_addr_W,
   output logic             o_rd_wren_W,
   output logic             o_valid_W,
   output logic             o_ld_misalign_W,
   output logic [CNT_W-1:0] o_retire_cnt
);

   localparam int SRC_ALU = 0;
   localparam int SRC_LD  = 1;
   localparam int SRC_PC4 = 2;
   localparam int SRC_CSR = 3;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef struct packed {
      logic             valid;
      logic [4:0]       rd_addr;
      logic             rd_wren;
      logic [SEL_W-1:0] wb_sel;
      logic [XLEN-1:0]  alu;
      logic [XLEN-1:0]  ld;
      logic [XLEN-1:0]  pc_4;
      logic [XLEN-1:0]  csr;
      logic [2:0]       ld_funct3;
      logic [1:0]       ld_addr_lo;
   } w_reg_t;

   w_reg_t           w_q, w_d;
   logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [XLEN-1:0]  ld_fmt;
   logic [XLEN-1:0]  result;
   logic             is_half, is_word, misalign;

   // Flush only kills the valid bit; the payload follows the normal stall rule.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      w_d = w_q;
      if (!i_stall_W) begin
         w_d.valid      = i_valid_M;
         w_d.rd_addr    = i_rd_addr_M;
         w_d.rd_wren    = i_rd_wren_M;
         w_d.wb_sel     = i_wb_sel_M;
         w_d.alu        = i_alu_data_M;
         w_d.ld         = i_ld_data_M;
         w_d.pc_4       = i_pc_4_M;
         w_d.csr        = i_csr_data_M;
         w_d.ld_funct3  = i_ld_funct3_M;
         w_d.ld_addr_lo = i_ld_addr_lo_M;
      end
      if (i_flush_W) begin
         w_d.valid = 1'b0;
      end
   end

   always_comb begin
      retire_cnt_d = retire_cnt_q;
      if (w_q.valid && !i_stall_W && !i_flush_W) begin
         retire_cnt_d = retire_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (i_reset) begin
         w_q          <= '0;
         retire_cnt_q <= '0;
      end else begin
         w_q          <= w_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   always_comb begin
      ld_byte = w_q.ld[{w_q.ld_addr_lo, 3'b000} +: 8];
      ld_half = w_q.ld[{w_q.ld_addr_lo[1], 4'b0000} +: 16];
      case (w_q.ld_funct3)
         F3_LB:   ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         F3_LH:   ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
         F3_LBU:  ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
         F3_LHU:  ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
         default: ld_fmt = w_q.ld;
      endcase
   end

   always_comb begin
      result = '0;
      if (int'(w_q.wb_sel) < NUM_SRC) begin
         case (int'(w_q.wb_sel))
            SRC_ALU: result = w_q.alu;
            SRC_LD:  result = ld_fmt;
            SRC_PC4: result = w_q.pc_4;
            SRC_CSR: result = w_q.csr;
            default: result = '0;
         endcase
      end
   end

   always_comb begin
      is_half  = (w_q.ld_funct3 == F3_LH) || (w_q.ld_funct3 == F3_LHU);
      is_word  = (w_q.ld_funct3 == F3_LW);
      misalign = w_q.valid && (int'(w_q.wb_sel) == SRC_LD) &&
                 ((is_half && w_q.ld_addr_lo[0]) || (is_word && (w_q.ld_addr_lo != 2'b00)));
   end

   assign o_result_W      = result;
   assign o_rd_addr_W     = w_q.rd_addr;
   assign o_rd_wren_W     = w_q.valid && w_q.rd_wren && (w_q.rd_addr != 5'd0) && !misalign;
   assign o_valid_W       = w_q.valid;
   assign o_ld_misalign_W = misalign;
   assign o_retire_cnt    = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for single-cycle behaviour plus
// hand sequences for stall/flush, async reset and counter wrap (CNT_W=4 copy).
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_m, stall_w, flush_w, rd_wren_m;
   logic [4:0]  rd_addr_m;
   logic [1:0]  wb_sel_m, ld_addr_lo_m;
   logic [2:0]  ld_funct3_m;
   logic [31:0] alu_m, ld_m, pc4_m, csr_m;

   logic [31:0] result_w, s_result_w;
   logic [4:0]  rd_addr_w, s_rd_addr_w;
   logic        rd_wren_w, valid_w, misalign_w;
   logic        s_rd_wren_w, s_valid_w, s_misalign_w;
   logic [31:0] retire_cnt;
   logic [3:0]  s_retire_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_stage dut (
      .i_clk(clk), .i_reset(rst), .i_valid_M(valid_m), .i_stall_W(stall_w),
      .i_flush_W(flush_w), .i_rd_addr_M(rd_addr_m), .i_rd_wren_M(rd_wren_m),
      .i_wb_sel_M(wb_sel_m), .i_alu_data_M(alu_m), .i_ld_data_M(ld_m),
      .i_pc_4_M(pc4_m), .i_csr_data_M(csr_m), .i_ld_funct3_M(ld_funct3_m),
      .i_ld_addr_lo_M(ld_addr_lo_m), .o_result_W(result_w), .o_rd_addr_W(rd_addr_w),
      .o_rd_wren_W(rd_wren_w), .o_valid_W(valid_w), .o_ld_misalign_W(misalign_w),
      .o_retire_cnt(retire_cnt)
   );

   wb_stage #(.CNT_W(4)) dut_small (
      .i_clk(clk), .i_reset(rst), .i_valid_M(valid_m), .i_stall_W(stall_w),
      .i_flush_W(flush_w), .i_rd_addr_M(rd_addr_m), .i_rd_wren_M(rd_wren_m),
      .i_wb_sel_M(wb_sel_m), .i_alu_data_M(alu_m), .i_ld_data_M(ld_m),
      .i_pc_4_M(pc4_m), .i_csr_data_M(csr_m), .i_ld_funct3_M(ld_funct3_m),
      .i_ld_addr_lo_M(ld_addr_lo_m), .o_result_W(s_result_w), .o_rd_addr_W(s_rd_addr_w),
      .o_rd_wren_W(s_rd_wren_w), .o_valid_W(s_valid_w), .o_ld_misalign_W(s_misalign_w),
      .o_retire_cnt(s_retire_cnt)
   );

   typedef struct {
      logic        valid, stall, flush;
      logic [4:0]  rd;
      logic        wren;
      logic [1:0]  sel;
      logic [31:0] alu, ld, pc4, csr;
      logic [2:0]  f3;
      logic [1:0]  lo;
      logic [31:0] e_res;
      logic [4:0]  e_rd;
      logic        e_wren, e_valid, e_mis;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [31:0] res, input logic [4:0] rd,
                             input logic wren, input logic vld, input logic mis,
                             input logic [31:0] cnt);
      check({tag, " result"}, result_w, res);
      check({tag, " rd_addr"}, 32'(rd_addr_w), 32'(rd));
      check({tag, " rd_wren"}, 32'(rd_wren_w), 32'(wren));
      check({tag, " valid"}, 32'(valid_w), 32'(vld));
      check({tag, " misalign"}, 32'(misalign_w), 32'(mis));
      check({tag, " retire_cnt"}, retire_cnt, cnt);
   endtask

   task automatic drive(input logic vld, input logic stl, input logic fls, input logic [4:0] rd,
                        input logic wren, input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] ld, input logic [31:0] pc4, input logic [31:0] csr,
                        input logic [2:0] f3, input logic [1:0] lo);
      valid_m = vld; stall_w = stl; flush_w = fls; rd_addr_m = rd; rd_wren_m = wren;
      wb_sel_m = sel; alu_m = alu; ld_m = ld; pc4_m = pc4; csr_m = csr;
      ld_funct3_m = f3; ld_addr_lo_m = lo;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse reset between edges and confirm everything clears before the next edge.
   task automatic async_reset(input string tag);
      #3 rst = 1'b1;
      #1;
      check_outs(tag, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      check({tag, " small retire_cnt"}, 32'(s_retire_cnt), 32'd0);
      #1 rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //           vld stl fls rd    wr sel   alu           ld            pc4           csr           f3      lo     e_res         e_rd   ew ev em e_cnt
      vecs[0]  = '{1, 0, 0, 5'd5,  1, 2'd1, 32'h0,        32'h000080FF, 32'h0,        32'h0,        3'b000, 2'd1, 32'hFFFFFF80, 5'd5,  1, 1, 0, 32'd0};
      vecs[1]  = '{1, 0, 0, 5'd6,  1, 2'd1, 32'h0,        32'h80010000, 32'h0,        32'h0,        3'b101, 2'd2, 32'h00008001, 5'd6,  1, 1, 0, 32'd1};
      vecs[2]  = '{1, 0, 0, 5'd7,  1, 2'd1, 32'h0,        32'h12345678, 32'h0,        32'h0,        3'b010, 2'd2, 32'h12345678, 5'd7,  0, 1, 1, 32'd2};
      vecs[3]  = '{1, 0, 0, 5'd0,  1, 2'd2, 32'h0,        32'h0,        32'h00000104, 32'h0,        3'b000, 2'd0, 32'h00000104, 5'd0,  0, 1, 0, 32'd3};
      vecs[4]  = '{1, 0, 0, 5'd31, 1, 2'd0, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        3'b000, 2'd0, 32'hDEADBEEF, 5'd31, 1, 1, 0, 32'd4};
      vecs[5]  = '{1, 0, 0, 5'd1,  0, 2'd3, 32'h0,        32'h0,        32'h0,        32'hCAFEF00D, 3'b000, 2'd0, 32'hCAFEF00D, 5'd1,  0, 1, 0, 32'd5};
      vecs[6]  = '{1, 0, 0, 5'd2,  1, 2'd1, 32'h0,        32'h7FFF8000, 32'h0,        32'h0,        3'b001, 2'd0, 32'hFFFF8000, 5'd2,  1, 1, 0, 32'd6};
      vecs[7]  = '{1, 0, 0, 5'd11, 1, 2'd1, 32'h0,        32'h7FFF8000, 32'h0,        32'h0,        3'b001, 2'd1, 32'hFFFF8000, 5'd11, 0, 1, 1, 32'd7};
      vecs[8]  = '{1, 0, 0, 5'd3,  1, 2'd1, 32'h0,        32'hAB000000, 32'h0,        32'h0,        3'b100, 2'd3, 32'h000000AB, 5'd3,  1, 1, 0, 32'd8};
      vecs[9]  = '{1, 0, 0, 5'd4,  1, 2'd1, 32'h0,        32'h00710000, 32'h0,        32'h0,        3'b000, 2'd2, 32'h00000071, 5'd4,  1, 1, 0, 32'd9};
      vecs[10] = '{0, 0, 0, 5'd8,  1, 2'd0, 32'h11111111, 32'h0,        32'h0,        32'h0,        3'b000, 2'd0, 32'h11111111, 5'd8,  0, 0, 0, 32'd10};
      vecs[11] = '{1, 0, 1, 5'd8,  1, 2'd0, 32'h11111111, 32'h0,        32'h0,        32'h0,        3'b000, 2'd0, 32'h11111111, 5'd8,  0, 0, 0, 32'd10};
      vecs[12] = '{1, 0, 0, 5'd9,  1, 2'd1, 32'h0,        32'hA5A5A5A5, 32'h0,        32'h0,        3'b011, 2'd0, 32'hA5A5A5A5, 5'd9,  1, 1, 0, 32'd10};
      vecs[13] = '{1, 0, 0, 5'd10, 1, 2'd1, 32'h0,        32'h89ABCDEF, 32'h0,        32'h0,        3'b010, 2'd0, 32'h89ABCDEF, 5'd10, 1, 1, 0, 32'd11};

      rst = 1'b1;
      drive(0, 0, 0, 5'd0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0);
      #2;
      check_outs("reset", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      #10 rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].valid, vecs[i].stall, vecs[i].flush, vecs[i].rd, vecs[i].wren,
               vecs[i].sel, vecs[i].alu, vecs[i].ld, vecs[i].pc4, vecs[i].csr,
               vecs[i].f3, vecs[i].lo);
         tick();
         check_outs($sformatf("vec%0d", i), vecs[i].e_res, vecs[i].e_rd, vecs[i].e_wren,
                    vecs[i].e_valid, vecs[i].e_mis, vecs[i].e_cnt);
      end

      // Stall three cycles with changing inputs: W frozen, count frozen.
      for (int k = 0; k < 3; k++) begin
         drive(1, 1, 0, 5'(20 + k), 1, 2'd0, 32'(k + 100), 32'h0, 32'h0, 32'h0, 3'b000, 2'd0);
         tick();
         check_outs($sformatf("stall%0d", k), 32'h89ABCDEF, 5'd10, 1'b1, 1'b1, 1'b0, 32'd11);
      end
      drive(1, 1, 1, 5'd23, 1, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0);
      tick();
      check("stall+flush valid", 32'(valid_w), 32'd0);
      check("stall+flush rd_wren", 32'(rd_wren_w), 32'd0);
      check("stall+flush retire_cnt", retire_cnt, 32'd11);
      drive(1, 0, 0, 5'd12, 1, 2'd2, 32'h0, 32'h0, 32'h00000200, 32'h0, 3'b000, 2'd0);
      tick();
      check_outs("post-flush", 32'h00000200, 5'd12, 1'b1, 1'b1, 1'b0, 32'd11);
      drive(0, 0, 0, 5'd0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0);
      tick();
      check("bubble retire_cnt", retire_cnt, 32'd12);

      // Reset asserted while an instruction is held by a stall.
      drive(1, 0, 0, 5'd13, 1, 2'd0, 32'h00000055, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0);
      tick();
      drive(1, 1, 0, 5'd13, 1, 2'd0, 32'h00000066, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0);
      tick();
      check("held result", result_w, 32'h00000055);
      async_reset("rst-stall");

      // Seventeen back-to-back instructions wrap the 4-bit counter.
      for (int i = 0; i < 17; i++) begin
         drive(1, 0, 0, 5'd1, 1, 2'd0, 32'(i), 32'h0, 32'h0, 32'h0, 3'b000, 2'd0);
         tick();
         check($sformatf("stream%0d result", i), result_w, 32'(i));
      end
      check("wrap small cnt at 16", 32'(s_retire_cnt), 32'd0);
      check("wrap main cnt at 16", retire_cnt, 32'd16);
      drive(0, 0, 0, 5'd0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0);
      tick();
      check("wrap small cnt", 32'(s_retire_cnt), 32'd1);
      check("wrap main cnt", retire_cnt, 32'd17);

      // Reset in the middle of a running stream, then resume.
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 5'd2, 1, 2'd0, 32'(i + 40), 32'h0, 32'h0, 32'h0, 3'b000, 2'd0);
         tick();
      end
      check("mid-stream small cnt", 32'(s_retire_cnt), 32'd3);
      async_reset("rst-stream");
      drive(1, 0, 0, 5'd14, 1, 2'd0, 32'h00000077, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0);
      tick();
      check_outs("resume", 32'h00000077, 5'd14, 1'b1, 1'b1, 1'b0, 32'd0);
      drive(0, 0, 0, 5'd0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0);
      tick();
      check("resume retire_cnt", retire_cnt, 32'd1);
      check("resume small retire_cnt", 32'(s_retire_cnt), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
